// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the instruction fetch unit: next-PC select encodings,
// the EBREAK/SYSTEM opcode that stops fetch, and the fetch FSM state type.
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

  // Next-PC select codes driven by the control stage (2'b11 is reserved and
  // behaves like sequential).
  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JALR   = 2'b10;

  // Major opcode of EBREAK; seeing it in the held instruction halts fetch.
  localparam logic [6:0] OPC_EBREAK = 7'b1110011;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

endpackage : fetch_unit_pkg

// File: rtl/pc_next.sv
// -----------------------------------------------------------------------------
// pc_next
// Combinational next-PC selection.
//   pc          : current PC
//   pc_src      : select (PC_SEQ / PC_BRANCH / PC_JALR / reserved -> sequential)
//   br_target   : PC+imm for branches and JAL
//   jalr_target : ALU result for JALR (bit 0 is cleared)
//   next_pc     : selected next PC (modulo 2^32)
//   misaligned  : next_pc is not word aligned
// -----------------------------------------------------------------------------
module pc_next
  import fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pc_src,
  input  logic [31:0] br_target,
  input  logic [31:0] jalr_target,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    next_pc = pc + 32'd4;
    case (pc_src)
      PC_BRANCH: next_pc = br_target;
      PC_JALR:   next_pc = jalr_target & 32'hFFFF_FFFE;
      default:   next_pc = pc + 32'd4;
    endcase
  end

  assign misaligned = |next_pc[1:0];

endmodule : pc_next

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Single-outstanding instruction fetch: request a word, hold it for decode
// until consumed, then step the PC (sequential / branch / jalr). Fetch stops
// on EBREAK or on a misaligned next PC; only reset restarts it.
//   clk, rst_n            : clock, asynchronous active-low reset
//   im_req/im_addr        : fetch request and byte address to instruction mem
//   im_ack/im_rdata       : memory response (data valid when im_ack)
//   im_data/im_valid      : registered instruction and its valid flag
//   pc/pc_plus4           : address of im_data and that address + 4
//   advance               : decode consumed the held instruction
//   PCsrc                 : next-PC select
//   br_target/jalr_target : branch/JAL and JALR targets
//   halted/misalign_err   : fetch stopped / stop caused by misaligned next PC
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic [31:0] im_data,
  output logic        im_valid,
  input  logic        advance,
  input  logic [1:0]  PCsrc,
  input  logic [31:0] br_target,
  input  logic [31:0] jalr_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        halted,
  output logic        misalign_err
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  im_data_q, im_data_d;
  logic         misalign_q, misalign_d;

  logic [31:0]  next_pc;
  logic         next_misaligned;

  pc_next u_pc_next (
    .pc          (pc_q),
    .pc_src      (PCsrc),
    .br_target   (br_target),
    .jalr_target (jalr_target),
    .next_pc     (next_pc),
    .misaligned  (next_misaligned)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    im_data_d  = im_data_q;
    misalign_d = misalign_q;
    case (state_q)
      FETCH: begin
        if (im_ack) begin
          im_data_d = im_rdata;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (advance) begin
          // EBREAK wins over a misaligned target; pc is kept in both halts.
          if (im_data_q[6:0] == OPC_EBREAK) begin
            state_d = HALT;
          end else if (next_misaligned) begin
            state_d    = HALT;
            misalign_d = 1'b1;
          end else begin
            pc_d    = next_pc;
            state_d = FETCH;
          end
        end
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      im_data_q  <= 32'h0;
      misalign_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so all flops update
      // from the same pre-edge values regardless of statement order.
      state_q    <= state_d;
      pc_q       <= pc_d;
      im_data_q  <= im_data_d;
      misalign_q <= misalign_d;
    end
  end

  // The reset state is FETCH, but no request may be visible while reset is
  // held; gating with rst_n makes the first request appear as soon as reset
  // releases and drops any outstanding request the instant reset asserts.
  assign im_req       = rst_n && (state_q == FETCH);
  assign im_addr      = pc_q;
  assign im_data      = im_data_q;
  assign im_valid     = (state_q == HOLD);
  assign pc           = pc_q;
  assign pc_plus4     = pc_q + 32'd4;
  assign halted       = (state_q == HALT);
  assign misalign_err = misalign_q;

endmodule : fetch_unit
